// File: rtl/icache_fetch_ctrl_if.sv
// Fetch-side bus bundle for icache_fetch_ctrl.
// It groups the Fetch1 request, icache request/response, Fetch2 delivery and the flush signals.
// The slave modport is the controller's view. The master modport is the surrounding pipeline's view.
interface icache_fetch_ctrl_if;
    logic        flush;
    logic        f1_req_valid;
    logic [31:0] f1_req_pc;
    logic        f1_req_rdy;
    logic        ic_req_valid;
    logic [31:0] ic_req_pc;
    logic        ic_ready;
    logic        ic_resp_valid;
    logic [31:0] ic_resp_data;
    logic        f2_data_valid;
    logic [31:0] f2_data;
    logic        f2_ack;

    modport slave (
        input  flush, f1_req_valid, f1_req_pc, ic_ready, ic_resp_valid, ic_resp_data, f2_ack,
        output f1_req_rdy, ic_req_valid, ic_req_pc, f2_data_valid, f2_data
    );

    modport master (
        output flush, f1_req_valid, f1_req_pc, ic_ready, ic_resp_valid, ic_resp_data, f2_ack,
        input  f1_req_rdy, ic_req_valid, ic_req_pc, f2_data_valid, f2_data
    );
endinterface

// File: rtl/icache_fetch_ctrl.sv
// icache_fetch_ctrl: sequences Fetch1 requests into the icache and buffers responses for Fetch2.
// The controller counts live and stale in-flight requests and buffered responses.
// A request is issued only while their sum is below MAX_OUT.
// Because of that bound, a response that cannot be back-pressured always finds room in the FIFO.
// A flush turns every live request into a stale one and empties the FIFO.
// Optional feature: define ICACHE_FETCH_PERF_EN to add the perf_stall_cnt and perf_drop_cnt outputs.
module icache_fetch_ctrl #(
    parameter int unsigned MAX_OUT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    icache_fetch_ctrl_if.slave   bus
`ifdef ICACHE_FETCH_PERF_EN
    ,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_drop_cnt
`endif
);

    localparam int unsigned CW = $clog2(MAX_OUT + 1);
    localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [CW+1:0] MAX_SUM  = (CW+2)'(MAX_OUT);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUT - 1);

    logic [CW-1:0] live_cnt;
    logic [CW-1:0] stale_cnt;
    logic [CW-1:0] fifo_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   mem [MAX_OUT];

    logic [CW+1:0] occ;
    logic          credit;
    logic          fire;
    logic          resp_stale;
    logic          resp_inflight;
    logic          resp_push;
    logic          resp_err;
    logic          pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Handshake outputs and response classification; outputs are held idle while in reset
    always_comb begin
        occ = (CW+2)'(live_cnt) + (CW+2)'(stale_cnt) + (CW+2)'(fifo_cnt);
        credit = (occ < MAX_SUM);
        bus.ic_req_valid  = rst_n & bus.f1_req_valid & ~bus.flush & credit;
        bus.f1_req_rdy    = rst_n & bus.ic_ready & ~bus.flush & credit;
        bus.ic_req_pc     = bus.f1_req_pc;
        bus.f2_data_valid = (fifo_cnt != '0);
        bus.f2_data       = mem[rd_ptr];
        fire          = bus.ic_req_valid & bus.ic_ready;
        resp_stale    = bus.ic_resp_valid & (stale_cnt != '0);
        resp_inflight = bus.ic_resp_valid & ((stale_cnt != '0) | (live_cnt != '0));
        resp_push     = bus.ic_resp_valid & (stale_cnt == '0) & (live_cnt != '0) & ~bus.flush;
        resp_err      = bus.ic_resp_valid & (stale_cnt == '0) & (live_cnt == '0);
        pop           = bus.f2_ack & (fifo_cnt != '0);
    end

    // Counter and FIFO pointer update; flush overrides all normal traffic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_cnt  <= '0;
            stale_cnt <= '0;
            fifo_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else if (bus.flush) begin
            // The response arriving in the flush cycle retires the oldest in-flight request.
            // That request is stale if any stale one exists, otherwise live, so the combined count drops by one.
            stale_cnt <= stale_cnt + live_cnt - CW'(resp_inflight);
            live_cnt  <= '0;
            fifo_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            live_cnt  <= live_cnt + CW'(fire) - CW'(resp_push);
            stale_cnt <= stale_cnt - CW'(resp_stale);
            fifo_cnt  <= fifo_cnt + CW'(resp_push) - CW'(pop);
            if (resp_push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)       rd_ptr <= ptr_next(rd_ptr);
        end
    end

    // Response storage; data needs no reset because fifo_cnt qualifies it
    always_ff @(posedge clk) begin
        if (resp_push) mem[wr_ptr] <= bus.ic_resp_data;
    end

`ifdef ICACHE_FETCH_PERF_EN
    logic stall_evt;
    logic drop_evt;

    // Performance event decode
    always_comb begin
        stall_evt = bus.f1_req_valid & ~bus.f1_req_rdy & ~bus.flush;
        drop_evt  = bus.ic_resp_valid & ((stale_cnt != '0) | bus.flush);
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            if (stall_evt && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (drop_evt && perf_drop_cnt != '1)   perf_drop_cnt  <= perf_drop_cnt + 32'd1;
        end
    end
`endif

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n) !resp_err);
    a_occupancy:      assert property (@(posedge clk) disable iff (!rst_n) occ <= MAX_SUM);

endmodule
